// File: rtl/haraka512_round_sched.sv
// Haraka-512 round scheduler: sequences an external 4-lane AES-round datapath
// through ROUNDS x (AES_PER_ROUND AES steps + one MIX step), then presents
// the feed-forward result P(x) XOR x until the consumer takes it.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       message-block handshake (in_ready high only in IDLE)
//   in_data    [511:0]      message block x
//   out_valid/out_ready     result handshake (out_valid high only in DONE)
//   out_data   [511:0]      P(x) XOR x, held until accepted
//   aes_state  [511:0]      current permutation state to the AES datapath
//   aes_rc_idx [5:0]        round-constant index (round*AES_PER_ROUND+step), 0 outside AES
//   aes_result [511:0]      combinational AES-round result from the datapath
//   busy                    high whenever the FSM is not IDLE
module haraka512_round_sched #(
  parameter int unsigned ROUNDS        = 5,
  parameter int unsigned AES_PER_ROUND = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic [511:0] aes_state,
  output logic [5:0]   aes_rc_idx,
  input  logic [511:0] aes_result,
  output logic         busy
);

  // Counters hold their terminal value (ROUNDS / AES_PER_ROUND) without wrapping.
  localparam int unsigned RW = $clog2(ROUNDS + 1);
  localparam int unsigned SW = $clog2(AES_PER_ROUND + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AES  = 2'd1;
  localparam logic [1:0] S_MIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    fsm, fsm_nxt;
  logic [RW-1:0] round, round_nxt;
  logic [SW-1:0] step, step_nxt;
  logic [511:0]  state, state_nxt;
  logic [511:0]  ff, ff_nxt;
  logic [511:0]  out_data_nxt;
  logic          in_ready_nxt, out_valid_nxt, busy_nxt;
  logic [5:0]    rc_nxt;
  logic [511:0]  mixed;

  // 32-bit word shuffle of the mix step; result listed MSB word first.
  function automatic logic [511:0] mix(input logic [511:0] s);
    logic [31:0] w [16];
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    return {w[14], w[6], w[10], w[2], w[5], w[13], w[1], w[9],
            w[4],  w[12], w[0], w[8], w[15], w[7], w[11], w[3]};
  endfunction

  assign mixed     = mix(state);
  assign aes_state = state;

  // Next-state and next-output logic.
  always_comb begin
    fsm_nxt      = fsm;
    round_nxt    = round;
    step_nxt     = step;
    state_nxt    = state;
    ff_nxt       = ff;
    out_data_nxt = out_data;
    case (fsm)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt = in_data;
          ff_nxt    = in_data;
          round_nxt = '0;
          step_nxt  = '0;
          fsm_nxt   = S_AES;
        end
      end
      S_AES: begin
        state_nxt = aes_result;
        step_nxt  = step + SW'(1);
        if (step == SW'(AES_PER_ROUND - 1)) fsm_nxt = S_MIX;
      end
      S_MIX: begin
        state_nxt = mixed;
        step_nxt  = '0;
        round_nxt = round + RW'(1);
        if (round == RW'(ROUNDS - 1)) begin
          fsm_nxt      = S_DONE;
          out_data_nxt = mixed ^ ff;
        end else begin
          fsm_nxt = S_AES;
        end
      end
      S_DONE: begin
        if (out_ready) fsm_nxt = S_IDLE;
      end
      default: fsm_nxt = S_IDLE;
    endcase
    // Outputs are registered, so they are derived from the next-cycle values.
    in_ready_nxt  = (fsm_nxt == S_IDLE);
    out_valid_nxt = (fsm_nxt == S_DONE);
    busy_nxt      = (fsm_nxt != S_IDLE);
    rc_nxt        = '0;
    if (fsm_nxt == S_AES)
      rc_nxt = 6'(round_nxt) * 6'(AES_PER_ROUND) + 6'(step_nxt);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      round      <= '0;
      step       <= '0;
      state      <= '0;
      ff         <= '0;
      out_data   <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      aes_rc_idx <= '0;
    end else begin
      fsm        <= fsm_nxt;
      round      <= round_nxt;
      step       <= step_nxt;
      state      <= state_nxt;
      ff         <= ff_nxt;
      out_data   <= out_data_nxt;
      in_ready   <= in_ready_nxt;
      out_valid  <= out_valid_nxt;
      busy       <= busy_nxt;
      aes_rc_idx <= rc_nxt;
    end
  end

endmodule

// File: tb/tb_haraka512_round_sched.sv
// Scoreboard bench for haraka512_round_sched: default instance (5 rounds x 2 AES
// steps) with identity / XOR AES stubs, plus a 1-round x 1-step instance.
module tb_haraka512_round_sched;

  localparam int unsigned LAT = 15;
  localparam int unsigned GAP = 17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic [511:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [511:0] out_data, aes_state, aes_result;
  logic [5:0]   aes_rc_idx;
  logic         xor_mode = 1'b0;

  logic         in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [511:0] in_data2 = '0;
  logic         in_ready2, out_valid2, busy2;
  logic [511:0] out_data2, aes_state2, aes_result2;
  logic [5:0]   aes_rc_idx2;

  haraka512_round_sched u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .aes_state(aes_state), .aes_rc_idx(aes_rc_idx),
    .aes_result(aes_result), .busy(busy));

  haraka512_round_sched #(.ROUNDS(1), .AES_PER_ROUND(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .aes_state(aes_state2), .aes_rc_idx(aes_rc_idx2),
    .aes_result(aes_result2), .busy(busy2));

  // AES datapath stubs.
  always_comb aes_result = xor_mode ? (aes_state ^ {16{{26'd0, aes_rc_idx}}}) : aes_state;
  assign aes_result2 = aes_state2;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [511:0] d; int unsigned t; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  bit seen = 1'b0;
  int unsigned last_acc = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
  endtask

  // Reference mix: result word j takes source word p[j].
  function automatic logic [511:0] ref_mix(input logic [511:0] s);
    int p[16];
    logic [511:0] r;
    p = '{3, 11, 7, 15, 8, 0, 12, 4, 9, 1, 13, 5, 2, 10, 6, 14};
    for (int j = 0; j < 16; j++) r[32*j +: 32] = s[32*p[j] +: 32];
    return r;
  endfunction

  function automatic logic [511:0] ref_perm(input logic [511:0] x, input bit xm);
    logic [511:0] s;
    logic [31:0]  k;
    s = x;
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 2; t++) begin
        k = 32'(r * 2 + t);
        if (xm) s = s ^ {16{k}};
      end
      s = ref_mix(s);
    end
    return s ^ x;
  endfunction

  function automatic logic [511:0] pack(input int w[16]);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = 32'(w[j]);
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // Offer a block (in_valid left high for the caller) and log its expectation.
  task automatic send(input logic [511:0] x, input logic [511:0] e, output int unsigned acc);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_data  = x;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    chk("accept_ready", 512'(in_ready), 512'(1));
    @(posedge clk); #1;
    acc = cyc;
    sb.push_back('{d: e, t: acc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 512'(sb.size()), 512'(0));
  endtask

  // Monitor: latency, data (every valid cycle, so also hold under backpressure), ready-vs-busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) chk("in_ready_while_busy", 512'(in_ready), 512'(0));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 512'(out_valid), 512'(0));
        end else begin
          if (!seen) chk("latency", 512'(cyc - sb[0].t), 512'(LAT));
          seen = 1'b1;
          chk("out_data", out_data, sb[0].d);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int w[16];
    int ew[16];
    int unsigned acc, a2;
    int n;
    logic [511:0] x, e;

    // Reset state.
    #3;
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_rc", 512'(aes_rc_idx), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    chk("rst_aes_state", aes_state, 512'(0));
    chk("rst_in_ready2", 512'(in_ready2), 512'(0));
    repeat (2) @(negedge clk);
    chk("rst_in_ready_held", 512'(in_ready), 512'(0));
    rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", 512'(in_ready), 512'(0));
    @(negedge clk);
    chk("rel_in_ready", 512'(in_ready), 512'(1));

    // Identity stub, w[i]=i: hand-computed mix^5(x) XOR x and rc sequence.
    for (int i = 0; i < 16; i++) w[i] = i;
    ew = '{12, 14, 3, 1, 1, 3, 14, 12, 8, 10, 7, 5, 5, 7, 10, 8};
    xor_mode = 1'b0;
    send(pack(w), pack(ew), acc);
    in_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("rc_seq", 512'(aes_rc_idx),
          512'((((k - 1) % 3) < 2) ? (2 * ((k - 1) / 3) + ((k - 1) % 3)) : 0));
      chk("busy_run", 512'(busy), 512'(1));
    end
    drain();

    // XOR stub, back-to-back random blocks.
    xor_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = rand512();
      send(x, ref_perm(x, 1'b1), acc);
      if (i > 0) chk("accept_interval", 512'(acc - last_acc), 512'(GAP));
      last_acc = acc;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: 20 cycles held, then a one-cycle out_ready pulse.
    out_ready = 1'b0;
    x = rand512();
    send(x, ref_perm(x, 1'b1), acc);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 512'(out_valid), 512'(1));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_out_valid_after", 512'(out_valid), 512'(0));
    chk("bp_in_ready_after", 512'(in_ready), 512'(1));
    chk("bp_busy_after", 512'(busy), 512'(0));
    chk("bp_drained", 512'(sb.size()), 512'(0));
    out_ready = 1'b1;

    // Reset at round 2, step 1.
    xor_mode = 1'b0;
    x = rand512();
    send(x, ref_perm(x, 1'b0), acc);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (aes_rc_idx != 6'd5 && n < 50);
    chk("mid_rc_reached", 512'(aes_rc_idx), 512'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 512'(out_valid), 512'(0));
    chk("mid_busy", 512'(busy), 512'(0));
    chk("mid_in_ready", 512'(in_ready), 512'(0));
    chk("mid_rc", 512'(aes_rc_idx), 512'(0));
    chk("mid_aes_state", aes_state, 512'(0));
    chk("mid_out_data", out_data, 512'(0));
    sb.delete();
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("no_stale_valid", 512'(out_valid), 512'(0));
    end
    xor_mode = 1'b1;
    x = rand512();
    send(x, ref_perm(x, 1'b1), acc);
    in_valid = 1'b0;
    drain();

    // One round, one AES step: latency 2, out = mix(x) XOR x with identity stub.
    ew = '{3, 10, 5, 12, 12, 5, 10, 3, 1, 8, 7, 14, 14, 7, 8, 1};
    e = pack(ew);
    @(posedge clk); #1;
    in_data2  = pack(w);
    in_valid2 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready2 && n < 50);
    chk("small_accept", 512'(in_ready2), 512'(1));
    @(posedge clk); #1;
    a2 = cyc;
    in_valid2 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid2 && n < 20);
    chk("small_valid", 512'(out_valid2), 512'(1));
    chk("small_latency", 512'(cyc - a2), 512'(2));
    chk("small_out_data", out_data2, e);
    @(negedge clk);
    chk("small_idle", 512'(in_ready2), 512'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/haraka512_round_sched.md
HARAKA512_ROUND_SCHED -- requirements
Module: haraka512_round_sched

Interface
REQ-001 Parameter ROUNDS, default 5, number of Haraka-512 rounds per permutation.
REQ-002 Parameter AES_PER_ROUND, default 2, AES-round steps per round before the mix step.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a 512-bit message block is offered.
REQ-006 in_ready  output  1  the block accepts a message block.
REQ-007 in_data  input  512  message block x.
REQ-008 out_valid  output  1  out_data holds a finished result.
REQ-009 out_ready  input  1  the consumer accepts the result.
REQ-010 out_data  output  512  P(x) XOR x, untruncated.
REQ-011 aes_state  output  512  current state, driven to the external 4-lane AES-round datapath.
REQ-012 aes_rc_idx  output  6  round-constant index for the external datapath.
REQ-013 aes_result  input  512  combinational AES-round result of aes_state and aes_rc_idx.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, AES, MIX and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and a transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-017 On transfer, the block SHALL load state and ff_reg from in_data, clear round and step counters, and enter AES.
REQ-018 In AES, each edge SHALL load state from aes_result and increment step, and the FSM SHALL enter MIX after step AES_PER_ROUND-1.
REQ-019 aes_rc_idx SHALL equal round*AES_PER_ROUND+step, zero-extended, and SHALL be 0 outside AES.
REQ-020 aes_state SHALL always equal the state register.
REQ-021 In MIX, one edge SHALL apply the word permutation, with word w[i] = bits 32i+31:32i of state.
REQ-022 The new state, MSB word first, SHALL be w14,w6,w10,w2,w5,w13,w1,w9,w4,w12,w0,w8,w15,w7,w11,w3.
REQ-023 After MIX, the block SHALL clear step and increment round, returning to AES if round < ROUNDS-1 and going to DONE otherwise.
REQ-024 On entry to DONE, the block SHALL register out_data as state XOR ff_reg.
REQ-025 out_valid SHALL be 1 exactly in DONE.
REQ-026 Latency from the accept edge to out_valid=1 SHALL be ROUNDS*(AES_PER_ROUND+1) cycles, 15 at defaults.
REQ-027 out_data SHALL be held stable while out_valid=1 and out_ready=0, for any length of backpressure.
REQ-028 When out_valid and out_ready are both 1 at an edge, the FSM SHALL return to IDLE, with no accept in that same cycle.
REQ-029 The minimum issue interval between accepts SHALL be latency+2 cycles, 17 at defaults.
REQ-030 in_valid and in_data SHALL be ignored outside IDLE.
REQ-031 aes_result SHALL be ignored outside AES.
REQ-032 Counter widths SHALL be sized from the parameters with no wrap before the terminal count.

Reset
REQ-033 While rst_n=0, the block SHALL force IDLE with counters, state, ff_reg and out_data all 0.
REQ-034 While rst_n=0, in_ready SHALL be 0; out_valid, busy and aes_rc_idx SHALL be 0.
REQ-035 On the first edge after rst_n rises, in_ready SHALL become 1.
REQ-036 Reset asserted mid-permutation SHALL abort the permutation immediately, and no out_valid SHALL follow.

Verification
REQ-037 Identity stub (aes_result=aes_state), in_data words w[i]=i -> after 15 cycles, out_data equals mix^5(x) XOR x, and aes_rc_idx sequence is 0..9 with exactly one idle cycle after every two AES steps.
REQ-038 XOR stub (aes_result = aes_state XOR {16{rc_idx}}), random x -> out_data matches the reference model for 1000 blocks.
REQ-039 Hold out_ready=0 for 20 cycles after out_valid -> out_data and out_valid remain stable; pulse out_ready -> IDLE on the next edge, and in_ready=1.
REQ-040 Back-to-back in_valid=1 -> accepts occur exactly every 17 cycles, and in_ready=0 throughout busy.
REQ-041 Drop rst_n at round 2, step 1 -> outputs are zeroed asynchronously, the next accepted block yields a correct result, and no stale out_valid appears.
REQ-042 ROUNDS=1, AES_PER_ROUND=1 -> latency is 2 cycles, and out_data = mix(aes_result(x)) XOR x.
